// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: registered lookup, per-way saturating counters,
// per-set round-robin victim pointers, sequential flush. Define BTB_BYPASS_EN to forward same-cycle updates.
module btb_assoc #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 5,
  parameter int SETS     = 256,
  parameter int WAYS     = 4,
  parameter int CNT_W    = 2
) (
  input  logic                     Clk,
  input  logic                     Rest,
  input  logic                     BtbStop,
  input  logic                     InstPcAble,
  input  logic [ADDR_W-1:0]        InstPc,
  input  logic                     UpAble,
  input  logic [ADDR_W-1:0]        UpPc,
  input  logic                     UpWayAble,
  input  logic [$clog2(WAYS)-1:0]  UpWay,
  input  logic                     UpTakenAble,
  input  logic                     UpTaken,
  input  logic                     UpTypeAble,
  input  logic [2:0]               UpType,
  input  logic                     UpTargetAble,
  input  logic [ADDR_W-1:0]        UpTarget,
  input  logic                     InvalAll,
  output logic                     InvalBusy,
  output logic                     InstNextAble,
  output logic [ADDR_W-1:0]        InstNextPc,
  output logic [2:0]               InstNextType,
  output logic                     InstNextTaken,
  output logic [WAYS-1:0]          InstHitWay
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;
  localparam logic [2:0] TypeFORMAL = 3'd0;
  localparam logic [2:0] TypeBRANCH = 3'd1;
  localparam logic [CNT_W-1:0] CntWeakT = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CntWeakN = ~CntWeakT;
  localparam logic [ADDR_W-1:0] BlkSize = ADDR_W'(1) << OFFSET_W;

  typedef enum logic {StIdle, StClear} flushState_t;
  flushState_t state, stateNext;
  logic [IDX_W-1:0] flushIdx;

  logic [WAYS-1:0]   validMem  [SETS];
  logic [TAG_W-1:0]  tagMem    [SETS][WAYS];
  logic [CNT_W-1:0]  cntMem    [SETS][WAYS];
  logic [2:0]        typeMem   [SETS][WAYS];
  logic [ADDR_W-1:0] tgtMem    [SETS][WAYS];
  logic [WAY_W-1:0]  victimPtr [SETS];

  logic unusedOffsetBits;
  assign unusedOffsetBits = ^{InstPc[OFFSET_W-1:0], UpPc[OFFSET_W-1:0]};

  // Lookup tag compare
  logic [IDX_W-1:0] lkIdx;
  logic [TAG_W-1:0] lkTag;
  logic             lkHit;
  logic [WAY_W-1:0] lkWay;
  assign lkIdx = InstPc[OFFSET_W+IDX_W-1:OFFSET_W];
  assign lkTag = InstPc[ADDR_W-1:OFFSET_W+IDX_W];

  always_comb begin
    lkHit = 1'b0;
    lkWay = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!lkHit && validMem[lkIdx][w] && tagMem[lkIdx][w] == lkTag) begin
        lkHit = 1'b1;
        lkWay = WAY_W'(w);
      end
    end
  end

  // Update way selection and new entry contents
  logic [IDX_W-1:0]  upIdx;
  logic [TAG_W-1:0]  upTag;
  logic              upDo, upHit, invFound, useVictim;
  logic [WAY_W-1:0]  upHitWay, invWay, wrWay;
  logic [CNT_W-1:0]  oldCnt, newCnt;
  logic [2:0]        newType;
  logic [ADDR_W-1:0] newTgt;
  assign upIdx = UpPc[OFFSET_W+IDX_W-1:OFFSET_W];
  assign upTag = UpPc[ADDR_W-1:OFFSET_W+IDX_W];
  assign upDo  = UpAble && (state == StIdle) && !InvalAll;

  always_comb begin
    upHit     = 1'b0;
    upHitWay  = '0;
    invFound  = 1'b0;
    invWay    = '0;
    useVictim = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!upHit && validMem[upIdx][w] && tagMem[upIdx][w] == upTag) begin
        upHit    = 1'b1;
        upHitWay = WAY_W'(w);
      end
      if (!invFound && !validMem[upIdx][w]) begin
        invFound = 1'b1;
        invWay   = WAY_W'(w);
      end
    end
    if (upHit)          wrWay = upHitWay;
    else if (UpWayAble) wrWay = UpWay;
    else if (invFound)  wrWay = invWay;
    else begin
      wrWay     = victimPtr[upIdx];
      useVictim = 1'b1;
    end
    oldCnt = cntMem[upIdx][wrWay];
    newCnt = oldCnt;
    if (UpTakenAble) begin
      if (!upHit)                       newCnt = UpTaken ? CntWeakT : CntWeakN;
      else if (UpTaken && oldCnt != '1) newCnt = oldCnt + 1'b1;
      else if (!UpTaken && oldCnt != '0) newCnt = oldCnt - 1'b1;
    end
    newType = UpTypeAble   ? UpType   : typeMem[upIdx][wrWay];
    newTgt  = UpTargetAble ? UpTarget : tgtMem[upIdx][wrWay];
  end

  // Lookup result before registering
  logic              rHit, rMsb, rTaken;
  logic [WAY_W-1:0]  rWay;
  logic [2:0]        rType;
  logic [ADDR_W-1:0] rTgt, rFall, rNextPc;
  logic [WAYS-1:0]   rHitVec;

  always_comb begin
    rHit  = lkHit;
    rWay  = lkWay;
    rType = typeMem[lkIdx][lkWay];
    rMsb  = cntMem[lkIdx][lkWay][CNT_W-1];
    rTgt  = tgtMem[lkIdx][lkWay];
`ifdef BTB_BYPASS_EN
    if (upDo && upIdx == lkIdx && upTag == lkTag) begin
      rHit  = 1'b1;
      rWay  = wrWay;
      rType = newType;
      rMsb  = newCnt[CNT_W-1];
      rTgt  = newTgt;
    end
`endif
    if (state == StClear) rHit = 1'b0;
    rFall   = (InstPc & ~(BlkSize - 1'b1)) + BlkSize;
    rTaken  = rHit && (rType != TypeBRANCH || rMsb);
    rNextPc = rTaken ? rTgt : rFall;
    rHitVec = '0;
    rHitVec[rWay] = rHit;
    if (!rHit) rType = TypeFORMAL;
  end

  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      InstNextAble  <= 1'b0;
      InstNextPc    <= '0;
      InstNextType  <= '0;
      InstNextTaken <= 1'b0;
      InstHitWay    <= '0;
    end else if (!BtbStop) begin
      InstNextAble  <= InstPcAble;
      InstNextPc    <= InstPcAble ? rNextPc : '0;
      InstNextType  <= InstPcAble ? rType   : '0;
      InstNextTaken <= InstPcAble && rTaken;
      InstHitWay    <= InstPcAble ? rHitVec : '0;
    end
  end

  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        validMem[s]  <= '0;
        victimPtr[s] <= '0;
      end
    end else if (state == StClear) begin
      validMem[flushIdx] <= '0;
    end else if (upDo) begin
      validMem[upIdx][wrWay] <= 1'b1;
      if (useVictim) victimPtr[upIdx] <= victimPtr[upIdx] + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (upDo) begin
      tagMem[upIdx][wrWay]  <= upTag;
      cntMem[upIdx][wrWay]  <= newCnt;
      typeMem[upIdx][wrWay] <= newType;
      tgtMem[upIdx][wrWay]  <= newTgt;
    end
  end

  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      state    <= StIdle;
      flushIdx <= '0;
    end else begin
      state    <= stateNext;
      flushIdx <= (state == StClear) ? flushIdx + 1'b1 : '0;
    end
  end

  always_comb begin
    stateNext = state;
    InvalBusy = 1'b0;
    case (state)
      StIdle:  if (InvalAll) stateNext = StClear;
      StClear: begin
        InvalBusy = 1'b1;
        if (flushIdx == IDX_W'(SETS - 1)) stateNext = StIdle;
      end
      default: stateNext = StIdle;
    endcase
  end
endmodule

// File: doc/btb_assoc.md
# btb_assoc

Parametrised set-associative branch target buffer for the BPU front end, replacing the fixed two-bank BTB. For each fetch block it performs a registered lookup across `WAYS` ways of `SETS` sets and returns the predicted next fetch PC, branch type and hit way to TAGE/RAS. Each way has a per-entry saturating direction counter, and each set has a round-robin victim pointer. A sequential invalidate-all engine flushes the table after context switches or `IBAR`.

## Interface
Parameters:
- `ADDR_W`, 32: PC width.
- `OFFSET_W`, 5: fetch-block offset bits; these are ignored and the block size is 2^OFFSET_W bytes.
- `SETS`, 256: number of sets, power of two. The index is `PC[OFFSET_W+IDX_W-1:OFFSET_W]`, where `IDX_W = log2(SETS)`.
- `WAYS`, 4: associativity, power of two, at least 2. `WAY_W = log2(WAYS)`.
- `CNT_W`, 2: saturating counter width.
- The tag is `PC[ADDR_W-1:OFFSET_W+IDX_W]`.

Ports:
- `Clk` in 1: clock.
- `Rest` in 1: asynchronous, active-high reset.
- `BtbStop` in 1: holds all lookup output registers.
- `InstPcAble` in 1, `InstPc` in ADDR_W: lookup request.
- `UpAble` in 1, `UpPc` in ADDR_W: update request.
- `UpWayAble` in 1, `UpWay` in WAY_W: way hint from predecode.
- `UpTakenAble` in 1, `UpTaken` in 1: direction training.
- `UpTypeAble` in 1, `UpType` in 3: type write.
- `UpTargetAble` in 1, `UpTarget` in ADDR_W: target write.
- `InvalAll` in 1: one-cycle pulse that starts a flush.
- `InvalBusy` out 1: high while the flush walks the table.
- `InstNextAble` out 1, `InstNextPc` out ADDR_W, `InstNextType` out 3, `InstNextTaken` out 1, `InstHitWay` out WAYS (one-hot): lookup result.

## Operation
- **Entry contents:** valid, tag, counter[CNT_W], type[3], target[ADDR_W].
- **Valid bits:** cleared by `Rest`. Data fields are not reset.
- **Lookup:** the indexed set is read and all ways are compared on tag and valid. If several ways hit, the lowest way wins.
  - Hit with type `TypeBRANCH`: the next PC is the target if counter MSB = 1, otherwise the fall-through.
  - Hit with any other type: the next PC is the target.
  - Miss: type is `TypeFORMAL`, the next PC is the fall-through, `InstHitWay` = 0, `InstNextTaken` = 0.
  - Fall-through = `{InstPc[ADDR_W-1:OFFSET_W], 0} + 2^OFFSET_W`, computed modulo 2^ADDR_W (wraps at the top of the address space).
  - `InstNextTaken` = 1 for a hit whose next PC is the target.
- **Update, tag hits in the set:** the hitting way is updated in place and the hint is ignored.
- **Update, tag misses:** a way is allocated.
  - If `UpWayAble` is set, the hinted way is used.
  - Otherwise the lowest invalid way is used.
  - Otherwise the set's victim pointer is used, and the pointer then increments modulo WAYS.
  - Allocation writes valid and tag. Only the fields whose `*Able` is set are written.
  - On allocation with `UpTakenAble` set, the counter is initialised to weakly taken (MSB = 1, others 0) if `UpTaken`, else weakly not-taken (MSB = 0, others 1).
- **Counter training:** an in-place update with `UpTakenAble` saturates the counter, +1 if taken and −1 if not taken, clamped to 0..2^CNT_W−1.
- **Flush FSM:**
  - IDLE → CLEAR on `InvalAll`.
  - CLEAR invalidates one set per cycle, starting at set 0. It moves to IDLE after set `SETS`−1.
  - `InvalBusy` = 1 exactly in CLEAR.
  - In CLEAR, lookups return miss results and updates are dropped. `InvalAll` is ignored while in CLEAR.

## Timing
- **Reset values:** all outputs are 0, the FSM is in IDLE, all victim pointers are 0, and all valid bits are 0.
- **Lookup latency:** one cycle; registered on the `Clk` edge after `InstPcAble`.
- **Output gating:** `BtbStop` has priority and all output registers hold. If `InstPcAble` is 0 and `BtbStop` is 0, all outputs return to 0 on the next edge.
- **Update write:** lands on the edge after `UpAble`. It is visible to lookups issued from the following cycle.
- **Same-cycle lookup and update to one set:** the lookup sees the pre-update contents, unless `BTB_BYPASS_EN` is defined.
- **Two updates to one set on consecutive cycles:** both apply in order. The second sees the first's allocation, so there is no duplicate tag.
- **Flush duration:** `SETS` cycles. `InvalBusy` rises on the edge after `InvalAll` and falls `SETS` edges later.
- **`Rest` during CLEAR:** the block returns immediately to IDLE with all entries invalid.
- **Same-cycle `InvalAll` and `UpAble` in IDLE:** the update is dropped.

## Configuration
- **`BTB_BYPASS_EN` defined:** an update in the same cycle as a lookup, with matching index and tag, is forwarded into the lookup result.
  - Forwarded fields: the new target, the new type, and the post-training counter MSB.
  - The hit way is the way being written.
- **`BTB_BYPASS_EN` not defined:** there is no forwarding; a lookup returns the stored contents from before that cycle.

## Test plan
- **Reset then lookup:** after reset, lookup `InstPc`=0x1000_0040 → next cycle `InstNextAble`=1, `InstNextPc`=0x1000_0060, `InstNextType`=`TypeFORMAL`, `InstHitWay`=0.
- **Allocate and train:**
  - Update 0x1000_0040 with type `TypeBRANCH`, target 0x2000_0000, taken=1 → lookup returns 0x2000_0000, `InstNextTaken`=1, hit one-hot way 0.
  - Two not-taken updates → lookup returns 0x1000_0060.
- **Fill and replace:** 5 distinct tags in set 3 with default `WAYS`=4 → the 5th allocation goes to way 0 (pointer 0→1); a 6th goes to way 1.
- **Saturation:** 4 taken updates → counter=3. One not-taken → 2; the prediction is still taken.
- **Flush:** `InvalAll` pulse → `InvalBusy` is high for 256 cycles, then all lookups miss. Assert `Rest` at cycle 100 of the flush → `InvalBusy`=0 immediately.
- **Same-cycle lookup and update:** lookup and update to the same set and tag in one cycle → old result without `BTB_BYPASS_EN`, new target with it. Hold with `BtbStop` for 3 cycles → outputs unchanged.
